// File: rtl/demux_rr_sequencer.sv
// Round-robin sequencer feeding an 8-way demux: grants pending channels in turn,
// holds sel with i high for the latched dwell, then one break-before-make gap cycle.
module demux_rr_sequencer #(
    parameter int NCH     = 8,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [NCH-1:0]     req,
    input  logic [DWELL_W-1:0] dwell,
    output logic [2:0]         sel,
    output logic               i,
    output logic [NCH-1:0]     gnt,
    output logic               busy,
    output logic               done
);

    localparam int SEL_W = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               i_q, i_d;
    logic [NCH-1:0]     gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [NCH-1:0]     pend_q, pend_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    logic               win_found;
    logic [SEL_W-1:0]   win_idx;
    logic [SEL_W-1:0]   cand;
    logic [NCH-1:0]     win_onehot;
    logic [NCH-1:0]     clr;
    logic [DWELL_W-1:0] dwell_load;
    logic               start;

    // Search ptr+1 .. ptr+NCH; 3-bit wrap gives the modulo-8 rotation for free.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            cand = ptr_q + SEL_W'(k);
            if (!win_found && pend_q[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_onehot = NCH'(1) << win_idx;
    assign start      = en & win_found;
    assign dwell_load = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        i_d     = i_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        clr     = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HOLD;
                    sel_d   = win_idx;
                    gnt_d   = win_onehot;
                    i_d     = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    ptr_d   = win_idx;
                    cnt_d   = dwell_load;
                end
            end
            S_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    state_d = S_GAP;
                    i_d     = 1'b0;
                    done_d  = 1'b1;
                    clr     = NCH'(1) << sel_q;
                end
            end
            S_GAP: begin
                // Chain straight into the next grant so back-to-back period is dwell+1.
                if (start) begin
                    state_d = S_HOLD;
                    sel_d   = win_idx;
                    gnt_d   = win_onehot;
                    i_d     = 1'b1;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    ptr_d   = win_idx;
                    cnt_d   = dwell_load;
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    gnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                i_d     = 1'b0;
                busy_d  = 1'b0;
                gnt_d   = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    // A request landing on the channel being cleared wins over the clear.
    assign pend_d = (pend_q & ~clr) | req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            i_q     <= 1'b0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pend_q  <= '0;
            ptr_q   <= SEL_W'(NCH - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            i_q     <= i_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel  = sel_q;
    assign i    = i_q;
    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_demux_rr_sequencer.sv
// Bench for demux_rr_sequencer: directed scenarios plus random traffic, all cycles
// compared against a grant/countdown reference model.
module tb_demux_rr_sequencer;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b0;
    logic [7:0] req   = '0;
    logic [3:0] dwell = '0;
    logic [2:0] sel;
    logic       i;
    logic [7:0] gnt;
    logic       busy;
    logic       done;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference state: pending set, last-granted channel, remaining high cycles, gap flag.
    logic [7:0]  m_pend;
    int unsigned m_ptr;
    int unsigned m_sel;
    int unsigned m_left;
    logic        m_gap;

    demux_rr_sequencer #(.NCH(8), .DWELL_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .req   (req),
        .dwell (dwell),
        .sel   (sel),
        .i     (i),
        .gnt   (gnt),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0;
        m_ptr  = 7;
        m_sel  = 0;
        m_left = 0;
        m_gap  = 1'b0;
    endtask

    task automatic model_step();
        logic [7:0]  clr;
        logic [7:0]  pv;
        int unsigned c;
        int unsigned w;
        bit          found;
        clr   = '0;
        pv    = m_pend;
        found = 1'b0;
        w     = 0;
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_gap = 1'b1;
                clr   = 8'd1 << m_sel;
            end
        end else begin
            for (int k = 1; k <= 8; k++) begin
                c = (m_ptr + k) % 8;
                if (!found && pv[c[2:0]]) begin
                    found = 1'b1;
                    w     = c;
                end
            end
            m_gap = 1'b0;
            if (en && found) begin
                m_sel  = w;
                m_ptr  = w;
                m_left = (dwell == 4'd0) ? 1 : 32'(dwell);
            end
        end
        m_pend = (m_pend & ~clr) | req;
    endtask

    task automatic compare_all();
        logic busy_e;
        busy_e = (m_left > 0) || m_gap;
        check("sel",  32'(sel),  m_sel);
        check("i",    32'(i),    32'(m_left > 0));
        check("gnt",  32'(gnt),  busy_e ? (32'd1 << m_sel) : 32'd0);
        check("busy", 32'(busy), 32'(busy_e));
        check("done", 32'(done), 32'(m_gap));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("rst_busy", 32'(busy), 32'd0);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2;
        compare_all();
        #10;
        reset = 1'b0;

        // Reset asserted asynchronously in the middle of a long HOLD, with ch6 still pending.
        en = 1'b1; dwell = 4'd9; req = 8'h42;
        step();
        req = '0;
        steps(3);
        check("pre_rst_busy", 32'(busy), 32'd1);
        async_reset();
        steps(4);
        check("post_rst_idle", 32'(busy), 32'd0);

        // Single request, dwell 3.
        en = 1'b1; dwell = 4'd3; req = 8'h20;
        step();
        req = '0;
        step();
        check("t2_sel", 32'(sel), 32'd5);
        check("t2_gnt", 32'(gnt), 32'h20);
        check("t2_i_first", 32'(i), 32'd1);
        steps(2);
        check("t2_i_last", 32'(i), 32'd1);
        step();
        check("t2_gap_i", 32'(i), 32'd0);
        check("t2_gap_done", 32'(done), 32'd1);
        step();
        check("t2_idle_busy", 32'(busy), 32'd0);
        check("t2_idle_done", 32'(done), 32'd0);

        // Two channels held: alternating 0,7,...
        async_reset();
        en = 1'b1; dwell = 4'd2; req = 8'h81;
        steps(2);
        check("t3_first", 32'(sel), 32'd0);
        steps(3);
        check("t3_second", 32'(sel), 32'd7);
        steps(3);
        check("t3_third", 32'(sel), 32'd0);
        steps(6);
        req = '0;
        steps(10);

        // All channels once with dwell 0 (treated as 1).
        async_reset();
        en = 1'b1; dwell = 4'd0; req = 8'hFF;
        step();
        req = '0;
        step();
        check("t4_ch0", 32'(sel), 32'd0);
        steps(2);
        check("t4_ch1", 32'(sel), 32'd1);
        steps(18);
        check("t4_idle", 32'(busy), 32'd0);

        // Request with en low: no grant until enabled.
        en = 1'b0; dwell = 4'd1; req = 8'h08;
        step();
        req = '0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("t5_no_grant", 32'(busy), 32'd0);
        end
        en = 1'b1;
        step();
        check("t5_sel", 32'(sel), 32'd3);
        check("t5_busy", 32'(busy), 32'd1);
        steps(6);

        // en dropped mid-HOLD on ch2 with ch4 pending.
        en = 1'b1; dwell = 4'd4; req = 8'h04;
        step();
        req = '0;
        step();
        check("t6_ch2", 32'(sel), 32'd2);
        req = 8'h10;
        step();
        req = '0; en = 1'b0;
        steps(6);
        check("t6_idle", 32'(busy), 32'd0);
        en = 1'b1;
        step();
        check("t6_ch4", 32'(sel), 32'd4);
        steps(8);

        // Random traffic with occasional asynchronous resets.
        async_reset();
        for (int n = 0; n < 3000; n++) begin
            req   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            en    = ($urandom_range(0, 7) != 0);
            dwell = 4'($urandom_range(0, 15));
            step();
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
